// File: rtl/bp_be_fe_queue_buffer_if.sv
// Handshake and data bundle between the FE queue buffer and its neighbours.
// The slave modport is the buffer itself; the master modport is the side that
// pushes fetch packets and drives the scheduler controls.
interface bp_be_fe_queue_buffer_if #(
  parameter int width_p          = 128,
  parameter int reg_addr_width_p = 5
);
  logic [width_p-1:0]          fe_queue_i;
  logic                        fe_queue_v_i;
  logic                        fe_queue_ready_o;
  logic [width_p-1:0]          fe_queue_o;
  logic                        fe_queue_v_o;
  logic                        fe_queue_yumi_i;
  logic                        clr_v_i;
  logic                        roll_v_i;
  logic                        deq_v_i;
  logic [reg_addr_width_p-1:0] rs1_addr_o;
  logic                        rs1_v_o;
  logic [reg_addr_width_p-1:0] rs2_addr_o;
  logic                        rs2_v_o;

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, clr_v_i, roll_v_i, deq_v_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o,
           rs1_addr_o, rs1_v_o, rs2_addr_o, rs2_v_o
  );

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, clr_v_i, roll_v_i, deq_v_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o,
           rs1_addr_o, rs1_v_o, rs2_addr_o, rs2_v_o
  );
endinterface

// File: rtl/bp_be_fe_queue_buffer.sv
// Circular buffer of FE queue packets between fetch and the backend scheduler.
// Three pointers track the queue: wptr (next free slot), rptr (next packet the
// scheduler will see) and cptr (oldest packet not yet committed). Packets that
// have been read but not committed still hold their slot, so a roll can replay
// them. The head instruction's rs1/rs2 fields are exposed for regfile pre-read.
module bp_be_fe_queue_buffer #(
  parameter int els_p            = 8,
  parameter int width_p          = 128,
  parameter int instr_lsb_p      = 0,
  parameter int reg_addr_width_p = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_be_fe_queue_buffer_if.slave q_if
);

  localparam int idx_width_lp = $clog2(els_p);
  localparam int ptr_width_lp = idx_width_lp + 1;
  localparam logic [ptr_width_lp-1:0] one_lp = ptr_width_lp'(1);

  logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic [ptr_width_lp-1:0] cptr_next;

  logic [width_p-1:0] mem [els_p];
  logic [width_p-1:0] head;

  logic full;
  logic ready;
  logic head_v;
  logic enq;

  // Full compares against the commit pointer: uncommitted reads still occupy space.
  assign full   = (wptr_r[idx_width_lp-1:0] == cptr_r[idx_width_lp-1:0])
                & (wptr_r[idx_width_lp] != cptr_r[idx_width_lp]);
  assign ready  = ~full & ~q_if.clr_v_i;
  assign head_v = (rptr_r != wptr_r);
  assign enq    = q_if.fe_queue_v_i & ready;

  assign cptr_next = cptr_r + ptr_width_lp'(q_if.deq_v_i);

  assign head = mem[rptr_r[idx_width_lp-1:0]];

  assign q_if.fe_queue_ready_o = ready;
  assign q_if.fe_queue_v_o     = head_v;
  assign q_if.fe_queue_o       = head;
  assign q_if.rs1_addr_o       = head[instr_lsb_p+15 +: reg_addr_width_p];
  assign q_if.rs2_addr_o       = head[instr_lsb_p+20 +: reg_addr_width_p];
  assign q_if.rs1_v_o          = q_if.fe_queue_yumi_i;
  assign q_if.rs2_v_o          = q_if.fe_queue_yumi_i;

  // Next-pointer selection: clr collapses everything onto the commit point,
  // roll rewinds only the read pointer, otherwise each pointer advances alone.
  always_comb begin
    wptr_n = wptr_r;
    rptr_n = rptr_r;
    cptr_n = cptr_next;
    if (q_if.clr_v_i) begin
      wptr_n = cptr_next;
      rptr_n = cptr_next;
    end else begin
      if (enq) begin
        wptr_n = wptr_r + one_lp;
      end
      if (q_if.roll_v_i) begin
        rptr_n = cptr_next;
      end else if (q_if.fe_queue_yumi_i) begin
        rptr_n = rptr_r + one_lp;
      end
    end
  end

  // Pointer registers; reset empties the queue without waiting for a clock edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  // Packet storage is written on accepted enqueues only and is never cleared.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wptr_r[idx_width_lp-1:0]] <= q_if.fe_queue_i;
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    q_if.fe_queue_yumi_i |-> head_v);
  a_deq_needs_read: assert property (@(posedge clk_i) disable iff (reset_i)
    q_if.deq_v_i |-> (cptr_r != rptr_r));
  a_enq_needs_ready: assert property (@(posedge clk_i) disable iff (reset_i)
    (q_if.fe_queue_v_i & ~q_if.clr_v_i) |-> ready);

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Testbench for bp_be_fe_queue_buffer. The reference model keeps the live
// packets as a plain queue (oldest uncommitted first) plus a count of how many
// of them the scheduler has already read. Stimulus pushes expectations into
// scoreboard queues; a negedge monitor pops and compares them.
module tb_bp_be_fe_queue_buffer;

  localparam int els_lp   = 8;
  localparam int width_lp = 128;
  localparam int rw_lp    = 5;

  logic clk;
  logic reset;

  bp_be_fe_queue_buffer_if #(.width_p(width_lp), .reg_addr_width_p(rw_lp)) q_if ();

  bp_be_fe_queue_buffer #(
    .els_p(els_lp), .width_p(width_lp), .instr_lsb_p(0), .reg_addr_width_p(rw_lp)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .q_if   (q_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [width_lp-1:0] mq[$];
  int nread;

  // Scoreboard queues.
  bit                  exp_v_q[$];
  bit                  exp_rdy_q[$];
  bit                  exp_rsv_q[$];
  logic [width_lp-1:0] exp_pkt_q[$];

  int compared;
  int mismatched;

  task automatic checkOutput(input string name, input logic [width_lp-1:0] act,
                             input logic [width_lp-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [width_lp-1:0] randPkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one cycle of inputs, records what the DUT must show this cycle,
  // advances the model, then waits to just after the next clock edge.
  task automatic applyStimulus(input bit enq, input logic [width_lp-1:0] d,
                               input bit yumi, input bit deq, input bit roll,
                               input bit clr);
    bit v_exp, rdy_exp;
    q_if.fe_queue_i      = d;
    q_if.fe_queue_v_i    = enq;
    q_if.fe_queue_yumi_i = yumi;
    q_if.deq_v_i         = deq;
    q_if.roll_v_i        = roll;
    q_if.clr_v_i         = clr;
    v_exp   = (nread < mq.size());
    rdy_exp = (mq.size() < els_lp) && !clr;
    exp_v_q.push_back(v_exp);
    exp_rdy_q.push_back(rdy_exp);
    exp_rsv_q.push_back(yumi);
    if (yumi) exp_pkt_q.push_back(mq[nread]);
    if (deq) begin
      void'(mq.pop_front());
      nread--;
    end
    if (clr) begin
      mq.delete();
      nread = 0;
    end else begin
      if (enq && rdy_exp) mq.push_back(d);
      if (roll) nread = 0;
      else if (yumi) nread++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drainAll();
    int guard = 0;
    while (mq.size() > 0 && guard < 100) begin
      applyStimulus(1'b0, '0, nread < mq.size(), nread > 0, 1'b0, 1'b0);
      guard++;
    end
  endtask

  // Reset between edges: outputs must respond before the next clock edge.
  task automatic doAsyncReset();
    q_if.fe_queue_v_i    = 1'b0;
    q_if.fe_queue_yumi_i = 1'b0;
    q_if.deq_v_i         = 1'b0;
    q_if.roll_v_i        = 1'b0;
    q_if.clr_v_i         = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_v", width_lp'(q_if.fe_queue_v_o), '0);
    checkOutput("async_rst_ready", width_lp'(q_if.fe_queue_ready_o), width_lp'(1));
    mq.delete();
    nread = 0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the DUT against whatever the stimulus recorded.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_v_q.size() > 0) begin
        checkOutput("head_valid", width_lp'(q_if.fe_queue_v_o), width_lp'(exp_v_q.pop_front()));
        checkOutput("ready", width_lp'(q_if.fe_queue_ready_o), width_lp'(exp_rdy_q.pop_front()));
        checkOutput("rs1_v", width_lp'(q_if.rs1_v_o), width_lp'(exp_rsv_q[0]));
        checkOutput("rs2_v", width_lp'(q_if.rs2_v_o), width_lp'(exp_rsv_q.pop_front()));
      end
      if (q_if.fe_queue_yumi_i) begin
        if (exp_pkt_q.size() == 0) begin
          checkOutput("unexpected_yumi", width_lp'(1), '0);
        end else begin
          logic [width_lp-1:0] p;
          logic [31:0] instr;
          p = exp_pkt_q.pop_front();
          instr = p[31:0];
          checkOutput("head_pkt", q_if.fe_queue_o, p);
          checkOutput("rs1_addr", width_lp'(q_if.rs1_addr_o), width_lp'(instr[19:15]));
          checkOutput("rs2_addr", width_lp'(q_if.rs2_addr_o), width_lp'(instr[24:20]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [width_lp-1:0] pkt;
    int sent;
    int guard;
    compared   = 0;
    mismatched = 0;
    nread      = 0;
    reset      = 1'b1;
    q_if.fe_queue_i      = '0;
    q_if.fe_queue_v_i    = 1'b0;
    q_if.fe_queue_yumi_i = 1'b0;
    q_if.deq_v_i         = 1'b0;
    q_if.roll_v_i        = 1'b0;
    q_if.clr_v_i         = 1'b0;
    #2;
    checkOutput("reset_v", width_lp'(q_if.fe_queue_v_o), '0);
    checkOutput("reset_ready", width_lp'(q_if.fe_queue_ready_o), width_lp'(1));
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle();

    // Basic flow: three enqueues then three reads.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randPkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    drainAll();

    // Full: read everything without committing, then commit one.
    for (int i = 0; i < els_lp; i++) applyStimulus(1'b1, randPkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < els_lp; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    applyStimulus(1'b1, randPkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    drainAll();

    // Roll with a concurrent commit: replay resumes at the second packet.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, randPkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drainAll();

    // Clear with a concurrent commit and a dropped enqueue.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randPkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, randPkt(), 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    applyStimulus(1'b1, randPkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drainAll();

    // Wrap: 20 sequence-numbered packets streamed with every operation active.
    sent  = 0;
    guard = 0;
    while ((sent < 20 || mq.size() > 0) && guard < 200) begin
      bit e;
      e = (sent < 20) && (mq.size() < els_lp);
      pkt = {96'(sent), $urandom};
      applyStimulus(e, pkt, nread < mq.size(), nread > 0, 1'b0, 1'b0);
      if (e) sent++;
      guard++;
    end
    checkOutput("wrap_all_sent", width_lp'(sent), width_lp'(20));

    // Async reset while holding four packets.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, randPkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    doAsyncReset();
    idle();
    applyStimulus(1'b1, randPkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drainAll();

    // Random legal traffic.
    for (int c = 0; c < 400; c++) begin
      bit e, y, d, r, k;
      e = ($urandom_range(0, 2) != 0) && (mq.size() < els_lp);
      y = ($urandom_range(0, 1) != 0) && (nread < mq.size());
      d = ($urandom_range(0, 2) == 0) && (nread > 0);
      r = ($urandom_range(0, 15) == 0);
      k = ($urandom_range(0, 31) == 0);
      applyStimulus(e, randPkt(), y, d, r, k);
    end
    drainAll();
    idle();

    @(negedge clk);
    checkOutput("scoreboard_empty", width_lp'(exp_pkt_q.size() + exp_v_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
